// File: rtl/vip_channel_extreme.sv
// Per-pixel channel reduction (min or max) through a registered comparator tree,
// with aligned sync delay, winning-channel index and a per-frame peak statistic.
module vip_channel_extreme #(
  parameter int  DW       = 8,
  parameter int  NCH      = 3,
  parameter int  MODE_MAX = 0,
  localparam int IW       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LAT      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [NCH*DW-1:0] per_img_data,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DW-1:0]     post_img_data,
  output logic [IW-1:0]     post_img_index,
  output logic [DW-1:0]     frame_peak,
  output logic              frame_peak_valid
);

  // Survivor slots are sized 2*NCH so pair reads never leave the array.
  localparam int NW = 2 * NCH;

  logic [NW*DW-1:0] in_pad;
  logic [DW-1:0]    val_d  [LAT][NW];
  logic [DW-1:0]    val_q  [LAT][NW];
  logic [IW-1:0]    idx_d  [LAT][NW];
  logic [IW-1:0]    idx_q  [LAT][NW];
  logic [2:0]       sync_d [LAT];
  logic [2:0]       sync_q [LAT];

  logic             vs_dly_d, vs_dly_q;
  logic [DW-1:0]    acc_d, acc_q;
  logic [DW-1:0]    peak_d, peak_q;
  logic             pv_d, pv_q;
  logic             counted, vs_rise, vs_fall;

  // Number of survivors left after tree level lvl.
  function automatic int survivors(input int lvl);
    int n;
    n = NCH;
    for (int j = 0; j <= lvl; j++) n = (n + 1) / 2;
    return n;
  endfunction

  // True when the upper (higher-index) candidate must win; ties keep the lower one.
  function automatic logic pick_b(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (MODE_MAX != 0) return b > a;
    return b < a;
  endfunction

  assign in_pad = {{(NCH*DW){1'b0}}, per_img_data};

  always_comb begin
    for (int j = 0; j < LAT; j++) begin
      for (int k = 0; k < NW; k++) begin
        val_d[j][k] = '0;
        idx_d[j][k] = '0;
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (2*k + 1 < NCH) begin
        if (pick_b(in_pad[2*k*DW +: DW], in_pad[(2*k+1)*DW +: DW])) begin
          val_d[0][k] = in_pad[(2*k+1)*DW +: DW];
          idx_d[0][k] = IW'(2*k + 1);
        end else begin
          val_d[0][k] = in_pad[2*k*DW +: DW];
          idx_d[0][k] = IW'(2*k);
        end
      end else if (2*k < NCH) begin
        val_d[0][k] = in_pad[2*k*DW +: DW];
        idx_d[0][k] = IW'(2*k);
      end
    end
    for (int j = 1; j < LAT; j++) begin
      for (int k = 0; k < NCH; k++) begin
        if (2*k + 1 < survivors(j - 1)) begin
          if (pick_b(val_q[j-1][2*k], val_q[j-1][2*k+1])) begin
            val_d[j][k] = val_q[j-1][2*k+1];
            idx_d[j][k] = idx_q[j-1][2*k+1];
          end else begin
            val_d[j][k] = val_q[j-1][2*k];
            idx_d[j][k] = idx_q[j-1][2*k];
          end
        end else if (2*k < survivors(j - 1)) begin
          val_d[j][k] = val_q[j-1][2*k];
          idx_d[j][k] = idx_q[j-1][2*k];
        end
      end
    end
  end

  // Stream has no backpressure: clken marks a valid pixel, and there is no ready.
  always_comb begin
    sync_d[0] = {per_frame_vsync, per_frame_href, per_frame_clken};
    for (int j = 1; j < LAT; j++) sync_d[j] = sync_q[j-1];
  end

  assign post_frame_vsync = sync_q[LAT-1][2];
  assign post_frame_href  = sync_q[LAT-1][1];
  assign post_frame_clken = sync_q[LAT-1][0];
  assign post_img_data    = val_q[LAT-1][0];
  assign post_img_index   = idx_q[LAT-1][0];
  assign frame_peak       = peak_q;
  assign frame_peak_valid = pv_q;

  assign counted = post_frame_vsync & post_frame_href & post_frame_clken;
  assign vs_rise = post_frame_vsync & ~vs_dly_q;
  assign vs_fall = ~post_frame_vsync & vs_dly_q;

  // The peak is always a maximum, whichever way the tree reduces.
  always_comb begin
    vs_dly_d = post_frame_vsync;
    acc_d    = acc_q;
    peak_d   = peak_q;
    pv_d     = 1'b0;
    if (vs_rise) begin
      acc_d = counted ? post_img_data : '0;
    end else if (counted && (post_img_data > acc_q)) begin
      acc_d = post_img_data;
    end
    if (vs_fall) begin
      peak_d = acc_q;
      pv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LAT; j++) begin
        sync_q[j] <= '0;
        for (int k = 0; k < NW; k++) begin
          val_q[j][k] <= '0;
          idx_q[j][k] <= '0;
        end
      end
      vs_dly_q <= 1'b0;
      acc_q    <= '0;
      peak_q   <= '0;
      pv_q     <= 1'b0;
    end else begin
      val_q    <= val_d;
      idx_q    <= idx_d;
      sync_q   <= sync_d;
      vs_dly_q <= vs_dly_d;
      acc_q    <= acc_d;
      peak_q   <= peak_d;
      pv_q     <= pv_d;
    end
  end

endmodule
